fsm_arb_rr: RTL and testbench

FSM_ARB_RR -- requirements
Module: fsm_arb_rr

---
 rtl/fsm_arb_pkg.sv | 13 +
 rtl/fsm_arb_rr_pick.sv | 28 ++
 rtl/fsm_arb_rr.sv | 107 ++++++++++
 tb/tb_fsm_arb_rr.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_arb_pkg.sv
// Shared types for the round-robin bus arbiter: FSM state encoding and default limits.
package fsm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BBUSY = 2'b01,
    BWAIT = 2'b10,
    BFREE = 2'b11
  } state_t;

  localparam int WAIT_MAX_DEF = 15;

endpackage

// File: rtl/fsm_arb_rr_pick.sv
// Combinational round-robin picker: scans from ptr+1 upward with wrap, first set req wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  int c;

  // Walk from the farthest offset to the nearest so the nearest hit overwrites.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      c = (int'(ptr) + off) % N_REQ;
      if (req[c]) begin
        valid = 1'b1;
        idx   = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/fsm_arb_rr.sv
// Round-robin bus arbiter FSM (IDLE/BBUSY/BWAIT/BFREE) with registered Moore outputs.
// Define FSM_ARB_TIMEOUT_EN to build the BWAIT hold-over limit counter and timeout pulse.
module fsm_arb_rr
  import fsm_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  input  logic             dly,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy,
  output logic             timeout
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic           pick_vld;
  logic [IDW-1:0] pick_idx;

`ifdef FSM_ARB_TIMEOUT_EN
  logic [7:0] wcnt;
`else
  localparam int unused_wait_max = WAIT_MAX;
`endif

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= IDW'(N_REQ - 1);
`ifdef FSM_ARB_TIMEOUT_EN
      wcnt    <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        // BFREE arbitrates exactly like IDLE; done/dly are not looked at here.
        IDLE, BFREE: begin
          if (pick_vld) begin
            state  <= BBUSY;
            gnt    <= ONE << pick_idx;
            gnt_id <= pick_idx;
            ptr    <= pick_idx;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
          end
        end
        BBUSY: begin
          if (done && dly) begin
            state <= BWAIT;
`ifdef FSM_ARB_TIMEOUT_EN
            wcnt  <= '0;
`endif
          end else if (done) begin
            state <= BFREE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        BWAIT: begin
          if (!dly) begin
            state <= BFREE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
`ifdef FSM_ARB_TIMEOUT_EN
          else if (wcnt == 8'(WAIT_MAX - 1)) begin
            state   <= BFREE;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_arb_rr.sv
// Directed self-checking bench for fsm_arb_rr (N_REQ=4, WAIT_MAX=15).
module tb_fsm_arb_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done, dly;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, timeout;

  int checks = 0;
  int errors = 0;

  fsm_arb_rr #(.N_REQ(4), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .dly(dly),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; done = 0; dly = 0;
    tick(); tick();
    checks++;
    if ({gnt, busy, timeout} !== 6'b0) begin
      errors++; $display("FAIL reset_out got %b want %b", {gnt, busy, timeout}, 6'b0);
    end
    checks++;
    if (gnt_id !== 2'd0) begin
      errors++; $display("FAIL reset_id got %0d want 0", gnt_id);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_id [4] = '{0, 2, 0, 2};
    logic [3:0] exp_g;
    rst_n = 1'b0; req = 4'b0101; done = 0; dly = 0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_g = 4'b0001 << exp_id[i];
      checks++;
      if ({gnt, busy} !== {exp_g, 1'b1} || gnt_id !== 2'(exp_id[i])) begin
        errors++; $display("FAIL rr_grant%0d got gnt=%b busy=%b id=%0d want gnt=%b busy=1 id=%0d",
                            i, gnt, busy, gnt_id, exp_g, exp_id[i]);
      end
      done = 1;
      tick();
      checks++;
      if ({gnt, busy} !== 5'b0) begin
        errors++; $display("FAIL rr_free%0d got gnt=%b busy=%b want 0", i, gnt, busy);
      end
      done = 0;
      if (i == 3) req = '0;
      tick();
    end
    checks++;
    if ({gnt, busy} !== 5'b0) begin
      errors++; $display("FAIL rr_idle got gnt=%b busy=%b want 0", gnt, busy);
    end
  endtask

  task automatic test_single();
    req = 4'b1000;
    tick();
    checks++;
    if ({gnt, busy} !== 5'b10001 || gnt_id !== 2'd3) begin
      errors++; $display("FAIL single_grant got gnt=%b busy=%b id=%0d want gnt=1000 busy=1 id=3", gnt, busy, gnt_id);
    end
    req = '0; done = 1; dly = 0;
    tick();
    checks++;
    if ({gnt, busy} !== 5'b0) begin
      errors++; $display("FAIL single_free got gnt=%b busy=%b want 0", gnt, busy);
    end
    done = 0;
    tick();
    checks++;
    if ({gnt, busy} !== 5'b0 || gnt_id !== 2'd3) begin
      errors++; $display("FAIL single_idle got gnt=%b busy=%b id=%0d want 0/0/3", gnt, busy, gnt_id);
    end
  endtask

  task automatic test_hold();
    req = 4'b0010;
    tick();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({gnt, busy} !== 5'b00101 || gnt_id !== 2'd1) begin
        errors++; $display("FAIL hold%0d got gnt=%b busy=%b id=%0d want gnt=0010 busy=1 id=1", i, gnt, busy, gnt_id);
      end
      tick();
    end
    req = '0; done = 1;
    tick();
    checks++;
    if ({gnt, busy} !== 5'b0 || gnt_id !== 2'd1) begin
      errors++; $display("FAIL hold_free got gnt=%b busy=%b id=%0d want 0/0/1", gnt, busy, gnt_id);
    end
    done = 0;
    tick();
  endtask

  task automatic test_wait();
    req = 4'b0001;
    tick();
    checks++;
    if ({gnt, busy} !== 5'b00011 || gnt_id !== 2'd0) begin
      errors++; $display("FAIL wait_grant got gnt=%b busy=%b id=%0d want gnt=0001 busy=1 id=0", gnt, busy, gnt_id);
    end
    req = '0; done = 1; dly = 1;
    tick();
    done = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({gnt, busy, timeout} !== 6'b000110) begin
        errors++; $display("FAIL wait_cyc%0d got %b want 000110", i, {gnt, busy, timeout});
      end
      if (i == 2) dly = 0;
      tick();
    end
    checks++;
    if ({gnt, busy, timeout} !== 6'b0) begin
      errors++; $display("FAIL wait_free got %b want 000000", {gnt, busy, timeout});
    end
    tick();
  endtask

  task automatic test_idle_ignore();
    done = 1; dly = 1;
    tick(); tick();
    checks++;
    if ({gnt, busy, timeout} !== 6'b0) begin
      errors++; $display("FAIL idle_ignore got %b want 000000", {gnt, busy, timeout});
    end
    done = 0; dly = 0;
    tick();
  endtask

  task automatic test_timeout();
    req = 4'b0001;
    tick();
    req = '0; done = 1; dly = 1;
    tick();
    done = 0;
`ifdef FSM_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      checks++;
      if ({gnt, busy, timeout} !== 6'b000110) begin
        errors++; $display("FAIL to_wait%0d got %b want 000110", i, {gnt, busy, timeout});
      end
      tick();
    end
    checks++;
    if ({gnt, busy, timeout} !== 6'b000001) begin
      errors++; $display("FAIL to_pulse got %b want 000001", {gnt, busy, timeout});
    end
    tick();
    checks++;
    if ({gnt, busy, timeout} !== 6'b0) begin
      errors++; $display("FAIL to_after got %b want 000000", {gnt, busy, timeout});
    end
    dly = 0;
`else
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if ({gnt, busy, timeout} !== 6'b000110) begin
      errors++; $display("FAIL to_stuck got %b want 000110", {gnt, busy, timeout});
    end
    dly = 0;
    tick();
    checks++;
    if ({gnt, busy, timeout} !== 6'b0) begin
      errors++; $display("FAIL to_release got %b want 000000", {gnt, busy, timeout});
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    tick();
    req = '0; done = 1; dly = 1;
    tick();
    done = 0;
    checks++;
    if ({gnt, busy} !== 5'b01001) begin
      errors++; $display("FAIL rmid_wait got gnt=%b busy=%b want gnt=0100 busy=1", gnt, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, busy, timeout} !== 6'b0 || gnt_id !== 2'd0) begin
      errors++; $display("FAIL rmid_async got out=%b id=%0d want 000000 id=0", {gnt, busy, timeout}, gnt_id);
    end
    dly = 0; req = 4'b1111;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({gnt, busy} !== 5'b00011 || gnt_id !== 2'd0) begin
      errors++; $display("FAIL rmid_first got gnt=%b busy=%b id=%0d want gnt=0001 busy=1 id=0", gnt, busy, gnt_id);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_hold();
    test_wait();
    test_idle_ignore();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
